// File: rtl/median9_pkg.sv
// ---------------------------------------------------------------------------
// median9_pkg
// Shared constants and types for the serial 9-sample median filter.
//   NSAMP  : samples per frame
//   MID    : index of the median in descending order (5th largest)
//   NPASS  : extraction passes needed to reach the median
//   state_t: control FSM states
//   step_t : operation applied to the register ring on one clock edge
// ---------------------------------------------------------------------------
package median9_pkg;

    localparam int NSAMP = 9;
    localparam int MID   = 4;
    localparam int NPASS = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SORT,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        STEP_LOAD,
        STEP_BYPASS,
        STEP_COMPUTE
    } step_t;

    // Number of compare steps in a pass; the remaining steps of the
    // 9-cycle pass are bypass rotations.
    function automatic logic [3:0] compute_steps(input logic [2:0] pass);
        return 4'(NSAMP - 1) - {1'b0, pass};
    endfunction

endpackage

// File: rtl/median9_ring.sv
// ---------------------------------------------------------------------------
// median9_ring
// Nine-register rotating ring R0..R8 with a single max/min comparator
// between R7 and R8. Every enabled edge shifts Ri <= Ri-1 for i=1..7; the
// step type decides what enters R0 and what stays in R8:
//   STEP_LOAD    : R0 <= din,          R8 <= R7
//   STEP_BYPASS  : R0 <= R8,           R8 <= R7
//   STEP_COMPUTE : R0 <= min(R7,R8),   R8 <= max(R7,R8)
// Ports:
//   CLK   in   clock, rising edge
//   nRST  in   asynchronous active-low reset, clears all registers
//   en    in   perform a step on this edge
//   step  in   step type (median9_pkg::step_t encoding)
//   din   in   sample to load
//   head  out  current contents of R0
// ---------------------------------------------------------------------------
module median9_ring
    import median9_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             en,
    input  logic [1:0]       step,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] r [NSAMP];
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    // Equal operands fall to the same value on both sides, so duplicates
    // need no special treatment.
    assign hi = (r[NSAMP-2] > r[NSAMP-1]) ? r[NSAMP-2] : r[NSAMP-1];
    assign lo = (r[NSAMP-2] > r[NSAMP-1]) ? r[NSAMP-1] : r[NSAMP-2];

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < NSAMP; i++) begin
                r[i] <= '0;
            end
        end else if (en) begin
            for (int i = 1; i < NSAMP - 1; i++) begin
                r[i] <= r[i-1];
            end
            case (step)
                STEP_LOAD: begin
                    r[0]       <= din;
                    r[NSAMP-1] <= r[NSAMP-2];
                end
                STEP_COMPUTE: begin
                    r[0]       <= lo;
                    r[NSAMP-1] <= hi;
                end
                default: begin
                    r[0]       <= r[NSAMP-1];
                    r[NSAMP-1] <= r[NSAMP-2];
                end
            endcase
        end
    end

    assign head = r[0];

endmodule

// File: rtl/median9_stream.sv
// ---------------------------------------------------------------------------
// median9_stream
// Serial 9-sample median filter for unsigned samples. A frame of 9 samples
// arrives on DI while DSI is high; a single-comparator ring extracts the
// five largest values over 5 passes of 9 cycles, and the 5th largest is
// presented on DO together with a rising DSO, 45 edges after the 9th sample.
// Ports:
//   CLK   in   clock, rising edge
//   nRST  in   asynchronous active-low reset
//   DSI   in   data strobe, high for 9 consecutive cycles per frame
//   DI    in   sample input
//   DO    out  median of the last complete frame (registered)
//   DSO   out  median valid (registered)
//   ERR   out  only with MEDIAN_ERR_EN defined: one-cycle pulse on a
//              truncated frame or an over-long strobe
// ---------------------------------------------------------------------------
module median9_stream
    import median9_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             DSI,
    input  logic [WIDTH-1:0] DI,
    output logic [WIDTH-1:0] DO,
    output logic             DSO
`ifdef MEDIAN_ERR_EN
    ,
    output logic             ERR
`endif
);

    state_t           state;
    state_t           next_state;
    step_t            ring_step;
    logic             ring_en;
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] median_q;
    logic [3:0]       sample_cnt;
    logic [3:0]       step_cnt;
    logic [2:0]       pass_cnt;
    logic             last_sample;
    logic             step_last;
    logic             pass_last;
    logic             sort_done;

    assign last_sample = (sample_cnt == 4'(NSAMP - 1));
    assign step_last   = (step_cnt == 4'(NSAMP - 1));
    assign pass_last   = (pass_cnt == 3'(NPASS - 1));
    assign sort_done   = (state == ST_SORT) && step_last && pass_last;

    median9_ring #(.WIDTH(WIDTH)) u_ring (
        .CLK  (CLK),
        .nRST (nRST),
        .en   (ring_en),
        .step (ring_step),
        .din  (DI),
        .head (head)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (DSI) next_state = ST_LOAD;
            ST_LOAD: begin
                if (!DSI) begin
                    next_state = ST_IDLE;
                end else if (last_sample) begin
                    next_state = ST_SORT;
                end
            end
            ST_SORT: if (sort_done) next_state = ST_SORT == ST_SORT ? ST_DONE : ST_SORT;
            ST_DONE: if (DSI) next_state = ST_LOAD;
            default: next_state = ST_IDLE;
        endcase
    end

    // Outside SORT the ring only moves when a sample is being captured;
    // a stale partial frame is simply overwritten by the next full one.
    always_comb begin
        ring_en   = 1'b0;
        ring_step = STEP_LOAD;
        case (state)
            ST_SORT: begin
                ring_en   = 1'b1;
                ring_step = (step_cnt < compute_steps(pass_cnt)) ? STEP_COMPUTE
                                                                 : STEP_BYPASS;
            end
            default: ring_en = DSI;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            sample_cnt <= '0;
            step_cnt   <= '0;
            pass_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: sample_cnt <= DSI ? 4'd1 : 4'd0;
                ST_LOAD: sample_cnt <= (DSI && !last_sample) ? sample_cnt + 4'd1 : 4'd0;
                default: sample_cnt <= '0;
            endcase
            if (state == ST_SORT) begin
                if (step_last) begin
                    step_cnt <= '0;
                    pass_cnt <= pass_last ? 3'd0 : pass_cnt + 3'd1;
                end else begin
                    step_cnt <= step_cnt + 4'd1;
                end
            end else begin
                step_cnt <= '0;
                pass_cnt <= '0;
            end
        end
    end

    // The ring ends the final pass with the largest value back in R0, so
    // the median is caught one edge after the final pass's first bypass
    // step, while it is the freshly extracted value sitting in R0. It is
    // held here so DO can change exactly when DSO rises.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            median_q <= '0;
            DO       <= '0;
            DSO      <= 1'b0;
        end else begin
            if (state == ST_SORT && pass_last && step_cnt == 4'(NSAMP - MID)) begin
                median_q <= head;
            end
            if (sort_done) begin
                DO  <= median_q;
                DSO <= 1'b1;
            end else if (state == ST_DONE && DSI) begin
                DSO <= 1'b0;
            end
        end
    end

`ifdef MEDIAN_ERR_EN
    // Strobe still high on the first SORT cycle means the source sent more
    // than 9 samples; those extras are ignored by the ring.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ERR <= 1'b0;
        end else begin
            ERR <= (state == ST_LOAD && !DSI) ||
                   (state == ST_SORT && pass_cnt == 3'd0 && step_cnt == 4'd0 && DSI);
        end
    end
`endif

endmodule

// File: tb/tb_median9_stream.sv
// ---------------------------------------------------------------------------
// tb_median9_stream
// Self-checking bench for median9_stream: directed frames, randomized
// back-to-back frames against a sort-based reference, a truncated frame,
// an asynchronous reset during SORT and strobe toggling during SORT.
// Build with MEDIAN_ERR_EN defined to also cover the ERR output.
// ---------------------------------------------------------------------------
module tb_median9_stream;

    localparam int WIDTH   = 8;
    localparam int LATENCY = 45;
    localparam int BOUND   = 60;

    logic             CLK;
    logic             nRST;
    logic             DSI;
    logic [WIDTH-1:0] DI;
    logic [WIDTH-1:0] DO;
    logic             DSO;
`ifdef MEDIAN_ERR_EN
    logic             ERR;
    int               errPulses = 0;
    int               errBase;
`endif

    int               checkCount = 0;
    int               errorCount = 0;
    int               prevMedian = 0;
    logic [WIDTH-1:0] frame [9];

    median9_stream #(.WIDTH(WIDTH)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .DSI  (DSI),
        .DI   (DI),
        .DO   (DO),
        .DSO  (DSO)
`ifdef MEDIAN_ERR_EN
        ,
        .ERR  (ERR)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

`ifdef MEDIAN_ERR_EN
    always @(negedge CLK) begin
        if (ERR === 1'b1) errPulses <= errPulses + 1;
    end
`endif

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    // 5th largest of the current frame, by plain descending sort
    function automatic int refMedian();
        int a [9];
        int t;
        for (int i = 0; i < 9; i++) a[i] = int'(frame[i]);
        for (int i = 0; i < 9; i++) begin
            for (int j = i + 1; j < 9; j++) begin
                if (a[j] > a[i]) begin
                    t = a[i]; a[i] = a[j]; a[j] = t;
                end
            end
        end
        return a[4];
    endfunction

    task automatic applyStimulus();
        for (int i = 0; i < 9; i++) begin
            @(negedge CLK);
            DSI = 1'b1;
            DI  = frame[i];
            @(posedge CLK);
            #1;
            if (i == 0) begin
                checkOutput("dso_clear", 32'(DSO), 32'd0);
                checkOutput("do_hold", 32'(DO), 32'(prevMedian));
            end
        end
    endtask

    task automatic waitResult(input bit toggle);
        int expected;
        int edges;
        expected = refMedian();
        edges = 0;
        while (edges < BOUND && DSO !== 1'b1) begin
            @(negedge CLK);
            DSI = toggle ? 1'($urandom_range(0, 1)) : 1'b0;
            DI  = 8'($urandom);
            @(posedge CLK);
            #1;
            edges++;
        end
        checkOutput("dso_rise", 32'(DSO), 32'd1);
        checkOutput("latency", 32'(edges), 32'(LATENCY));
        checkOutput("median", 32'(DO), 32'(expected));
        prevMedian = expected;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge CLK);
            DSI = 1'b0;
        end
    endtask

    initial begin
        nRST = 1'b0;
        DSI  = 1'b0;
        DI   = '0;
        repeat (2) @(negedge CLK);
        checkOutput("reset_do", 32'(DO), 32'd0);
        checkOutput("reset_dso", 32'(DSO), 32'd0);
        nRST = 1'b1;
        idle(2);

        $display("[TB] directed frames");
        for (int i = 0; i < 9; i++) frame[i] = 8'(10 * (i + 1));
        applyStimulus();
        waitResult(1'b0);
        checkOutput("asc_50", 32'(DO), 32'd50);
        idle(3);

        for (int i = 0; i < 9; i++) frame[i] = 8'(255 - i);
        applyStimulus();
        waitResult(1'b0);
        checkOutput("desc_251", 32'(DO), 32'd251);
        idle(2);

        for (int i = 0; i < 9; i++) frame[i] = 8'd7;
        applyStimulus();
        waitResult(1'b0);
        checkOutput("equal_7", 32'(DO), 32'd7);
        idle(2);

        for (int i = 0; i < 8; i++) frame[i] = (i % 2 == 0) ? 8'd0 : 8'd255;
        frame[8] = 8'd128;
        applyStimulus();
        waitResult(1'b0);
        checkOutput("extreme_128", 32'(DO), 32'd128);
        idle(2);

        $display("[TB] strobe toggling during sort");
        for (int i = 0; i < 9; i++) frame[i] = 8'($urandom);
        applyStimulus();
        waitResult(1'b1);
        idle(2);

        $display("[TB] truncated frame");
`ifdef MEDIAN_ERR_EN
        errBase = errPulses;
`endif
        for (int i = 0; i < 9; i++) frame[i] = 8'(200 + i);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            DSI = 1'b1;
            DI  = frame[i];
            @(posedge CLK);
            #1;
            if (i == 0) checkOutput("abort_dso_clear", 32'(DSO), 32'd0);
        end
        idle(3);
        @(posedge CLK);
        #1;
        checkOutput("abort_do", 32'(DO), 32'(prevMedian));
        checkOutput("abort_dso", 32'(DSO), 32'd0);
        for (int i = 0; i < 9; i++) frame[i] = 8'(i + 1);
        applyStimulus();
        waitResult(1'b0);
        checkOutput("after_abort_5", 32'(DO), 32'd5);
`ifdef MEDIAN_ERR_EN
        checkOutput("err_pulses", 32'(errPulses - errBase), 32'd1);
`endif
        idle(2);

        $display("[TB] reset during sort");
        for (int i = 0; i < 9; i++) frame[i] = 8'($urandom);
        applyStimulus();
        idle(20);
        @(posedge CLK);
        #3;
        nRST = 1'b0;
        #1;
        checkOutput("rst_do", 32'(DO), 32'd0);
        checkOutput("rst_dso", 32'(DSO), 32'd0);
        @(negedge CLK);
        nRST = 1'b1;
        prevMedian = 0;
        idle(2);
        for (int i = 0; i < 9; i++) frame[i] = 8'(9 - i);
        applyStimulus();
        waitResult(1'b0);
        checkOutput("after_rst_5", 32'(DO), 32'd5);

        $display("[TB] random back-to-back frames");
        for (int n = 0; n < 1000; n++) begin
            for (int i = 0; i < 9; i++) begin
                frame[i] = (n % 2 == 0) ? 8'($urandom_range(0, 255))
                                        : 8'($urandom_range(0, 15));
            end
            applyStimulus();
            waitResult(1'b0);
        end
        idle(2);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
